riscv_mem_arbiter: RTL and testbench

- Shares one single-port unified memory bus between the pipeline's instruction-fetch port (IF, read-only) and data port (MEM stage, read/write).
- Sits between riscv_pipelined_core and the memory model.
- Arbitrates requests, sequences one bus transaction at a time, and returns data with one-cycle valid pulses. The pipeline stalls on `req && !valid`.
- Includes a bus-timeout watchdog.

---
 rtl/riscv_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory bus arbiter for the IF and MEM ports, with a bus timeout.
// Define ARB_FAIRNESS_EN to bound consecutive data grants while IF waits.
module riscv_mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 16,
  parameter int FAIR_LIMIT = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_if_req,
  input  logic [WIDTH-1:0] i_if_addr,
  output logic [WIDTH-1:0] o_if_rdata,
  output logic             o_if_valid,
  input  logic             i_dm_req,
  input  logic             i_dm_we,
  input  logic [WIDTH-1:0] i_dm_addr,
  input  logic [WIDTH-1:0] i_dm_wdata,
  input  logic [3:0]       i_dm_byteen,
  output logic [WIDTH-1:0] o_dm_rdata,
  output logic             o_dm_valid,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic [3:0]       o_mem_byteen,
  input  logic [WIDTH-1:0] i_mem_rdata,
  input  logic             i_mem_ready,
  output logic             o_err,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUS_IF,
    BUS_DM,
    DONE
  } state_t;

  localparam int CW = $clog2(TIMEOUT);
  localparam int FW = $clog2(FAIR_LIMIT + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    wait_q;
  logic [FW-1:0]    fair_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [3:0]       mem_byteen_q;
  logic [WIDTH-1:0] if_rdata_q;
  logic [WIDTH-1:0] dm_rdata_q;
  logic             if_valid_q;
  logic             dm_valid_q;
  logic             err_q;

  logic grant_dm, grant_if;
  logic fin_ok, fin_to, fin;
  logic in_bus;
  logic fair_hit;

  assign in_bus   = (state_q == BUS_IF) || (state_q == BUS_DM);
  assign fin      = fin_ok || fin_to;
  assign fair_hit = FAIR_EN && (fair_q == FAIR_MAX);

  always_comb begin
    state_d  = state_q;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    fin_ok   = 1'b0;
    fin_to   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_dm_req && !(fair_hit && i_if_req)) begin
          grant_dm = 1'b1;
          state_d  = BUS_DM;
        end else if (i_if_req) begin
          grant_if = 1'b1;
          state_d  = BUS_IF;
        end
      end
      BUS_IF, BUS_DM: begin
        // a ready on the last allowed cycle still completes normally
        if (i_mem_ready) begin
          fin_ok  = 1'b1;
          state_d = DONE;
        end else if (wait_q == TO_LAST) begin
          fin_to  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      fair_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_byteen_q <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= fin && (state_q == BUS_IF);
      dm_valid_q <= fin && (state_q == BUS_DM);
      err_q      <= fin_to;
      if (in_bus && !fin) wait_q <= wait_q + 1'b1;
      else                wait_q <= '0;
      if (grant_dm) begin
        mem_we_q     <= i_dm_we;
        mem_addr_q   <= i_dm_addr;
        mem_wdata_q  <= i_dm_wdata;
        mem_byteen_q <= i_dm_byteen;
        if (!i_if_req)              fair_q <= '0;
        else if (fair_q != FAIR_MAX) fair_q <= fair_q + 1'b1;
      end
      if (grant_if) begin
        mem_we_q     <= 1'b0;
        mem_addr_q   <= i_if_addr;
        mem_wdata_q  <= '0;
        mem_byteen_q <= 4'b1111;
        fair_q       <= '0;
      end
      if (fin && state_q == BUS_IF)
        if_rdata_q <= fin_ok ? i_mem_rdata : '0;
      if (fin && state_q == BUS_DM)
        dm_rdata_q <= fin_ok ? i_mem_rdata : '0;
    end
  end

  assign o_mem_req    = in_bus;
  assign o_mem_we     = mem_we_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_byteen = mem_byteen_q;
  assign o_if_rdata   = if_rdata_q;
  assign o_dm_rdata   = dm_rdata_q;
  assign o_if_valid   = if_valid_q;
  assign o_dm_valid   = dm_valid_q;
  assign o_err        = err_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: directed requests, a simple memory
// model, and monitors for completions and bus transactions.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [3:0]  i_dm_byteen;
  logic [31:0] o_dm_rdata;
  logic        o_dm_valid;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_byteen;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ready;
  logic        o_err;
  logic        o_busy;

  riscv_mem_arbiter #(.WIDTH(32), .TIMEOUT(16), .FAIR_LIMIT(4)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_byteen(i_dm_byteen),
    .o_dm_rdata(o_dm_rdata), .o_dm_valid(o_dm_valid),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_byteen(o_mem_byteen),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
    bit          chk_rd;
    bit          err;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    int          len;
  } bus_t;

  exp_t sbq[$];
  bus_t busq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mem_wait = 0;
  bit   mem_never = 0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model: ready after mem_wait bus cycles unless mem_never
  initial begin
    int mcnt = 0;
    i_mem_ready = 1'b0;
    i_mem_rdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      if (o_mem_req) begin
        i_mem_ready = !mem_never && (mcnt == mem_wait);
        i_mem_rdata = i_mem_ready ? model_rd(o_mem_addr) : 32'hBAD0BAD0;
        mcnt++;
      end else begin
        i_mem_ready = 1'b0;
        i_mem_rdata = 32'hBAD0BAD0;
        mcnt = 0;
      end
    end
  end

  // completion monitor
  initial begin
    bit pv = 0;
    forever begin
      @(negedge clk);
      if (o_if_valid || o_dm_valid) begin
        chk("both_valid", {31'b0, o_if_valid & o_dm_valid}, 32'd0);
        chk("pulse_width", {31'b0, pv}, 32'd0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: if=%b dm=%b", o_if_valid, o_dm_valid);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("port_is_if", {31'b0, o_if_valid}, {31'b0, e.is_if});
          chk("err", {31'b0, o_err}, {31'b0, e.err});
          if (e.chk_rd)
            chk("rdata", e.is_if ? o_if_rdata : o_dm_rdata, e.rdata);
          if (e.cyc >= 0) chk("latency", cyc, e.cyc);
        end
      end
      pv = o_if_valid || o_dm_valid;
    end
  end

  // bus monitor
  initial begin
    bit   pr = 0;
    int   run = 0;
    bus_t cur;
    cur.len = -1;
    forever begin
      @(negedge clk);
      if (o_mem_req && !pr) begin
        run = 0;
        if (busq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus: addr=%h", o_mem_addr);
          cur.len = -1;
        end else begin
          cur = busq.pop_front();
          chk("bus_we", {31'b0, o_mem_we}, {31'b0, cur.we});
          chk("bus_addr", o_mem_addr, cur.addr);
          chk("bus_wdata", o_mem_wdata, cur.wdata);
          chk("bus_byteen", {28'b0, o_mem_byteen}, {28'b0, cur.byteen});
        end
      end
      if (o_mem_req) run++;
      if (!o_mem_req && pr && cur.len >= 0) chk("bus_len", run, cur.len);
      pr = o_mem_req;
    end
  end

  task automatic wait_valid(input bit is_if);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = is_if ? o_if_valid : o_dm_valid;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: is_if=%0d got no pulse", is_if);
    end
  endtask

  task automatic do_if(input logic [31:0] a);
    i_if_addr = a;
    i_if_req  = 1'b1;
    wait_valid(1'b1);
    i_if_req = 1'b0;
  endtask

  task automatic do_dm(input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    i_dm_we     = we;
    i_dm_addr   = a;
    i_dm_wdata  = wd;
    i_dm_byteen = be;
    i_dm_req    = 1'b1;
    wait_valid(1'b0);
    i_dm_req = 1'b0;
  endtask

  function automatic void exp_if(input logic [31:0] a, input logic [31:0] rd,
                                 input bit err, input int len, input int c);
    sbq.push_back('{1'b1, rd, 1'b1, err, c});
    busq.push_back('{1'b0, a, 32'h0, 4'hF, len});
  endfunction

  function automatic void exp_dm(input bit we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input int len);
    sbq.push_back('{1'b0, model_rd(a), !we, 1'b0, -1});
    busq.push_back('{we, a, wd, be, len});
  endfunction

  initial begin
    logic [31:0] hold;
    int nv;
    i_reset = 1'b1;
    i_if_req = 0; i_if_addr = 0;
    i_dm_req = 0; i_dm_we = 0; i_dm_addr = 0; i_dm_wdata = 0; i_dm_byteen = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    chk("rst_valids", {30'b0, o_if_valid, o_dm_valid}, 32'd0);
    chk("rst_if_rdata", o_if_rdata, 32'd0);
    chk("rst_dm_rdata", o_dm_rdata, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    i_reset = 1'b0;
    @(negedge clk);

    // IF-only read, zero-wait, with latency check
    mem_wait = 0;
    exp_if(32'h100, 32'h00500093, 1'b0, 1, cyc + 2);
    do_if(32'h100);
    @(negedge clk);

    // store with three bus cycles
    mem_wait = 2;
    exp_dm(1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 3);
    do_dm(1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011);
    @(negedge clk);

    // simultaneous requests: data first
    mem_wait = 0;
    exp_dm(1'b0, 32'h200, 32'h0, 4'hF, 1);
    exp_if(32'h10, model_rd(32'h10), 1'b0, 1, -1);
    fork
      do_dm(1'b0, 32'h200, 32'h0, 4'hF);
      do_if(32'h10);
    join
    @(negedge clk);

    // data completion leaves IF rdata untouched
    hold = o_if_rdata;
    exp_dm(1'b0, 32'h240, 32'h0, 4'hF, 1);
    do_dm(1'b0, 32'h240, 32'h0, 4'hF);
    chk("if_rdata_hold", o_if_rdata, model_rd(32'h10));
    chk("if_rdata_same", o_if_rdata, hold);
    @(negedge clk);

    // timeout, then ready exactly on the last allowed cycle
    mem_never = 1;
    exp_if(32'h300, 32'h0, 1'b1, 16, -1);
    do_if(32'h300);
    @(negedge clk);
    mem_never = 0;
    mem_wait = 15;
    exp_if(32'h304, model_rd(32'h304), 1'b0, 16, -1);
    do_if(32'h304);
    @(negedge clk);

    // reset while in BUS_DM
    mem_never = 1;
    busq.push_back('{1'b1, 32'h3000, 32'h12345678, 4'hF, -1});
    i_dm_we = 1; i_dm_addr = 32'h3000; i_dm_wdata = 32'h12345678;
    i_dm_byteen = 4'hF; i_dm_req = 1;
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'b0, o_busy}, 32'd1);
    i_reset = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, o_mem_req}, 32'd0);
    chk("mid_rst_busy", {31'b0, o_busy}, 32'd0);
    i_dm_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_dm_rdata", o_dm_rdata, 32'd0);
    i_reset = 1'b0;
    mem_never = 0;
    mem_wait = 0;
    @(negedge clk);
    exp_if(32'h104, model_rd(32'h104), 1'b0, 1, -1);
    do_if(32'h104);
    @(negedge clk);

    // both requests held continuously
`ifdef ARB_FAIRNESS_EN
    for (int k = 0; k < 4; k++) exp_dm(1'b0, 32'h400, 32'h0, 4'hF, 1);
    exp_if(32'h20, model_rd(32'h20), 1'b0, 1, -1);
`else
    for (int k = 0; k < 5; k++) exp_dm(1'b0, 32'h400, 32'h0, 4'hF, 1);
`endif
    i_dm_we = 0; i_dm_addr = 32'h400; i_dm_wdata = 0; i_dm_byteen = 4'hF;
    i_if_addr = 32'h20;
    i_dm_req = 1; i_if_req = 1;
    nv = 0;
    for (int i = 0; i < 200 && nv < 5; i++) begin
      @(negedge clk);
      if (o_if_valid || o_dm_valid) nv++;
    end
    i_dm_req = 0;
    i_if_req = 0;
    chk("hold_completions", nv, 5);
    repeat (5) @(negedge clk);

    chk("sb_empty", sbq.size(), 0);
    chk("bus_empty", busq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
